// File: rtl/regm_arbiter_pkg.sv
// Shared types and defaults for the regm register-store arbiter.
// Imported by the arbiter top; the round-robin helper stays package-free for reuse.
package regm_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } arb_state_e;

   localparam int DEF_ID_W    = 8;
   localparam int DEF_DATA_W  = 32;
   localparam int STORE_W     = DEF_ID_W + DEF_DATA_W;
   localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/regm_arbiter_rr.sv
// Round-robin grant over N requesters: searches upward from ptr, wrapping to 0.
// Produces a one-hot grant plus its index; all-zero grant when nothing requests.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   int   idx;
   logic found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found        = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/regm_arbiter.sv
// Shares one regm register store between NUM_REQ requesters: serialises writes and
// reads onto the regm strobes and routes the single outstanding read back with a timeout.
module regm_arbiter
   import regm_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = DEF_ID_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic [NUM_REQ-1:0]        rq_valid,
   input  logic [NUM_REQ-1:0]        rq_write,
   input  logic [NUM_REQ*ID_W-1:0]   rq_id,
   input  logic [NUM_REQ*DATA_W-1:0] rq_wdata,
   output logic [NUM_REQ-1:0]        rq_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic                      rsp_err,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      m_store_data_f,
   output logic [ID_W+DATA_W-1:0]    m_store_data,
   output logic                      m_req_id_f,
   output logic [ID_W-1:0]           m_req_id,
   input  logic [DATA_W-1:0]         m_req_data,
   input  logic                      m_req_data_f
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam int SW    = ID_W + DATA_W;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

   arb_state_e          state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                store_f_q, store_f_d;
   logic [SW-1:0]       store_q, store_d;
   logic                req_f_q, req_f_d;
   logic [ID_W-1:0]     req_id_q, req_id_d;
   logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

   logic [NUM_REQ-1:0]  gnt;
   logic [IDX_W-1:0]    gnt_idx;
   logic [ID_W-1:0]     g_id;
   logic [DATA_W-1:0]   g_wdata;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req     (rq_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Grants are only offered while no read is outstanding.
   assign rq_ready = (state_q == IDLE) ? gnt : '0;

   assign g_id    = rq_id[int'(gnt_idx)*ID_W +: ID_W];
   assign g_wdata = rq_wdata[int'(gnt_idx)*DATA_W +: DATA_W];

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      store_f_d   = 1'b0;
      store_d     = '0;
      req_f_d     = 1'b0;
      req_id_d    = '0;
      rsp_valid_d = '0;
      rsp_err_d   = 1'b0;
      rsp_data_d  = '0;
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
               if (rq_write[gnt_idx]) begin
                  store_f_d = 1'b1;
                  store_d   = {g_id, g_wdata};
               end else begin
                  req_f_d  = 1'b1;
                  req_id_d = g_id;
                  owner_d  = gnt_idx;
                  cnt_d    = '0;
                  state_d  = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            // Returning data beats a coincident timeout.
            if (m_req_data_f) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_data_d           = m_req_data;
               state_d              = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               rsp_valid_d[owner_q] = 1'b1;
               rsp_err_d            = 1'b1;
               state_d              = IDLE;
            end else begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         store_f_q   <= 1'b0;
         store_q     <= '0;
         req_f_q     <= 1'b0;
         req_id_q    <= '0;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         store_f_q   <= store_f_d;
         store_q     <= store_d;
         req_f_q     <= req_f_d;
         req_id_q    <= req_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign m_store_data_f = store_f_q;
   assign m_store_data   = store_q;
   assign m_req_id_f     = req_f_q;
   assign m_req_id       = req_id_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_err        = rsp_err_q;
   assign rsp_data       = rsp_data_q;

endmodule
